// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART command-frame parser and its TX responder.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_CHECK   = 2'd2
  } state_t;

  localparam logic [7:0] RSP_OK      = 8'h00;
  localparam logic [7:0] RSP_CRC_ERR = 8'hE1;
  localparam logic [7:0] RSP_TIMEOUT = 8'hE2;

  localparam logic [7:0]  HEADER_BYTE_DEF = 8'hAA;
  localparam logic [7:0]  CRC_POLY_DEF    = 8'h07;
  localparam logic [7:0]  CRC_INIT_DEF    = 8'h00;
  localparam int unsigned PAYLOAD_LEN_DEF = 11;
  localparam int unsigned TIMEOUT_CYC_DEF = 43400;

endpackage

// File: rtl/crc8_step.sv
// One-byte CRC-8 update, MSB-first, no reflection; purely combinational.
module crc8_step #(
  parameter logic [7:0] POLY = 8'h07
) (
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  always_comb begin
    crc_out = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[7] ? ({crc_out[6:0], 1'b0} ^ POLY) : {crc_out[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles header-delimited UART bytes into fixed-length frames, checks CRC-8 and
// commits good payloads atomically to the register-mapper bus.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int unsigned PAYLOAD_LEN = PAYLOAD_LEN_DEF,
  parameter logic [7:0]  HEADER_BYTE = HEADER_BYTE_DEF,
  parameter logic [7:0]  CRC_POLY    = CRC_POLY_DEF,
  parameter logic [7:0]  CRC_INIT    = CRC_INIT_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [7:0]               uart_data,
  input  logic                     uart_done,
  output logic [8*PAYLOAD_LEN-1:0] rev_data_bus,
  output logic                     pack_done,
  output logic                     recv_done,
  output logic [7:0]               response_data,
  output logic [7:0]               pack_num,
  output logic                     frame_busy
);

  localparam int unsigned IDX_W = $clog2(PAYLOAD_LEN);
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_TERM = GAP_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_MAX  = '1;

  state_t state_q, state_d;

  logic [PAYLOAD_LEN-1:0][7:0] shadow_q;
  logic [IDX_W-1:0]            idx_q;
  logic [7:0]                  crc_q;
  logic [7:0]                  crc_next_c;
  logic [GAP_W-1:0]            gap_q;

  logic gap_term_c;
  logic start_c;
  logic capture_c;
  logic commit_c;
  logic crc_err_c;
  logic timeout_c;

  crc8_step #(
    .POLY(CRC_POLY)
  ) u_crc8_step (
    .crc_in (crc_q),
    .data   (uart_data),
    .crc_out(crc_next_c)
  );

  assign gap_term_c = (gap_q == GAP_TERM);

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and per-cycle frame events; a byte always beats the timeout
  always_comb begin
    state_d   = state_q;
    start_c   = 1'b0;
    capture_c = 1'b0;
    commit_c  = 1'b0;
    crc_err_c = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (uart_done && (uart_data == HEADER_BYTE)) begin
          start_c = 1'b1;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (uart_done) begin
          capture_c = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_CHECK;
          end
        end else if (gap_term_c) begin
          timeout_c = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (uart_done) begin
          if (uart_data == crc_q) begin
            commit_c = 1'b1;
          end else begin
            crc_err_c = 1'b1;
          end
          state_d = ST_IDLE;
        end else if (gap_term_c) begin
          timeout_c = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame assembly: shadow buffer, byte index, running CRC
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      shadow_q <= '0;
      idx_q    <= '0;
      crc_q    <= 8'h00;
    end else begin
      if (start_c) begin
        idx_q <= '0;
        crc_q <= CRC_INIT;
      end else if (capture_c) begin
        shadow_q[idx_q] <= uart_data;
        idx_q           <= idx_q + IDX_W'(1);
        crc_q           <= crc_next_c;
      end
    end
  end

  // Inter-byte gap counter: held clear outside a frame, saturating inside
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      gap_q <= '0;
    end else if ((state_q == ST_IDLE) || (state_d == ST_IDLE) || uart_done) begin
      gap_q <= '0;
    end else if (gap_q != GAP_MAX) begin
      gap_q <= gap_q + GAP_W'(1);
    end
  end

  // Registered outputs to the mapper and the TX responder
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rev_data_bus  <= '0;
      pack_done     <= 1'b0;
      recv_done     <= 1'b0;
      response_data <= RSP_OK;
      pack_num      <= 8'h00;
      frame_busy    <= 1'b0;
    end else begin
      pack_done  <= commit_c;
      recv_done  <= commit_c | crc_err_c | timeout_c;
      frame_busy <= (state_d != ST_IDLE);
      if (commit_c) begin
        rev_data_bus  <= shadow_q;
        pack_num      <= pack_num + 8'd1;
        response_data <= RSP_OK;
      end else if (crc_err_c) begin
        response_data <= RSP_CRC_ERR;
      end else if (timeout_c) begin
        response_data <= RSP_TIMEOUT;
      end
    end
  end

endmodule
